// File: rtl/sar_pkg.sv
// sar_pkg: shared definitions for the SAR control stage.
//   sar_state_t   - conversion FSM states
//   SAR_NBIT_MAX  - largest supported resolution
//   sar_latency() - cycles from the edge accepting start to dout_valid high
package sar_pkg;

    localparam int SAR_NBIT_MAX = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RESET  = 3'd1,
        SAMPLE = 3'd2,
        SHARE  = 3'd3,
        CONV   = 3'd4,
        DONE   = 3'd5
    } sar_state_t;

    // One acceptance cycle, RESET, SAMPLE, one SHARE cycle, NBIT CONV
    // cycles; dout_valid is registered on the edge entering DONE.
    function automatic int sar_latency(input int nbit, input int rst_cyc,
                                       input int smp_cyc);
        return rst_cyc + smp_cyc + nbit + 2;
    endfunction

endpackage

// File: rtl/sar_phase_cnt.sv
// sar_phase_cnt: loadable down-counter with a zero flag, used to time the
// RESET and SAMPLE phases of the SAR controller.
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset
//   load       - load load_val (has priority over dec)
//   load_val   - value loaded on load
//   dec        - decrement by one; saturates at zero
//   zero       - counter is zero
module sar_phase_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sar_ctrl.sv
// sar_ctrl: SAR ADC control stage. Sequences the sample-and-hold through
// reset, track and charge-share phases, then runs an NBIT-step binary
// search on the comparator decision and reports the final code.
// Build option: define SAR_CTRL_FREERUN_EN to restart a new conversion
// directly from DONE (free-running after the first start).
// Ports:
//   clk, rstn   - conversion clock, asynchronous active-low reset
//   start       - conversion request, sampled only in IDLE
//   comp        - comparator decision, 1 = keep the current trial bit
//   snh_rst     - S/H reset phase
//   sample      - S/H track phase
//   cs_trigger  - S/H charge-share pulse (one cycle)
//   cmp_en      - comparator enable, high during CONV
//   dac_code    - trial code to the CDAC
//   dout        - last completed conversion result
//   dout_valid  - one-cycle strobe qualifying dout
//   busy        - high in every state except IDLE
//   fsm_state   - current FSM state (debug observation)
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int NBIT    = 8,
    parameter int RST_CYC = 2,
    parameter int SMP_CYC = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            comp,
    output logic            snh_rst,
    output logic            sample,
    output logic            cs_trigger,
    output logic            cmp_en,
    output logic [NBIT-1:0] dac_code,
    output logic [NBIT-1:0] dout,
    output logic            dout_valid,
    output logic            busy,
    output sar_state_t      fsm_state
);

    localparam int CNT_MAX = (RST_CYC > SMP_CYC) ? RST_CYC : SMP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = $clog2(NBIT);

    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] SMP_LOAD = CNT_W'(SMP_CYC - 1);
    localparam logic [NBIT-1:0]  CODE_MSB = {1'b1, {(NBIT-1){1'b0}}};
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(NBIT - 1);

    // Handshake: start is a level request. An edge in IDLE that sees start=1
    // accepts it; start at any other time has no effect. dout_valid is a
    // one-cycle strobe with no back-pressure; dout holds until the next
    // result or reset.

    sar_state_t       state;
    sar_state_t       next_state;
    logic             start_acc;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] bit_idx_nxt;
    logic [NBIT-1:0]  code_nxt;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    sar_phase_cnt #(
        .W (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state and phase-counter control.
    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_val    = RST_LOAD;
        case (state)
            IDLE: begin
                if (start_acc) begin
                    next_state = RESET;
                    cnt_load   = 1'b1;
                    cnt_val    = RST_LOAD;
                end
            end
            RESET: begin
                if (cnt_zero) begin
                    next_state = SAMPLE;
                    cnt_load   = 1'b1;
                    cnt_val    = SMP_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SAMPLE: begin
                if (cnt_zero) begin
                    next_state = SHARE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SHARE: begin
                next_state = CONV;
            end
            CONV: begin
                if (bit_idx == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
`ifdef SAR_CTRL_FREERUN_EN
                next_state = RESET;
                cnt_load   = 1'b1;
                cnt_val    = RST_LOAD;
`else
                next_state = IDLE;
`endif
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Binary-search datapath: resolve bit i from comp, then raise bit i-1
    // as the next trial. The MSB trial is loaded on entry to SHARE so the
    // CDAC has settled before the first comparison.
    always_comb begin
        code_nxt    = dac_code;
        bit_idx_nxt = bit_idx;
        if (state == CONV) begin
            if (!comp) begin
                code_nxt[bit_idx] = 1'b0;
            end
            if (bit_idx != '0) begin
                code_nxt[bit_idx - IDX_W'(1)] = 1'b1;
                bit_idx_nxt                   = bit_idx - IDX_W'(1);
            end
        end
        if (next_state == SHARE) begin
            code_nxt    = CODE_MSB;
            bit_idx_nxt = IDX_MSB;
        end
    end

    // Outputs are registered from next_state so they line up with the
    // state register. start is first captured in start_acc, which keeps
    // start off every output path and makes busy rise one cycle after the
    // accepting edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            start_acc  <= 1'b0;
            bit_idx    <= '0;
            dac_code   <= '0;
            dout       <= '0;
            snh_rst    <= 1'b0;
            sample     <= 1'b0;
            cs_trigger <= 1'b0;
            cmp_en     <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= next_state;
            start_acc  <= (state == IDLE) && start && !start_acc;
            bit_idx    <= bit_idx_nxt;
            dac_code   <= code_nxt;
            snh_rst    <= (next_state == RESET);
            sample     <= (next_state == SAMPLE);
            cs_trigger <= (next_state == SHARE);
            cmp_en     <= (next_state == CONV);
            dout_valid <= (next_state == DONE);
            busy       <= (next_state != IDLE);
            if ((state == CONV) && (next_state == DONE)) begin
                dout <= code_nxt;
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: doc/sar_ctrl.md
# sar_ctrl

Synchronous SAR control stage, directly downstream of the ADC sample-and-hold in the SAR ADC example. It sequences the S/H through reset, track and charge-share phases via `snh_rst`, `sample` and `cs_trigger`, then runs an N-step binary search on the comparator decision. It drives the DAC trial code each step and emits the final code with a one-cycle valid strobe.

## Interface
Parameters:
- `NBIT`, 8: resolution; legal range 2..16.
- `RST_CYC`, 2: cycles with `snh_rst` high; must be ≥1.
- `SMP_CYC`, 4: cycles with `sample` high; must be ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  conversion clock; all state changes on its rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `start`  in  1  conversion request; sampled only in IDLE.
- `comp`  in  1  comparator decision: 1 = vin ≥ vdac, keep the trial bit.
- `snh_rst`  out  1  drives S/H `rst`.
- `sample`  out  1  drives S/H `sample`.
- `cs_trigger`  out  1  drives S/H `cs_trigger`; one-cycle pulse.
- `cmp_en`  out  1  comparator enable; high during CONV.
- `dac_code`  out  NBIT  current trial code to the CDAC.
- `dout`  out  NBIT  last completed conversion result.
- `dout_valid`  out  1  one-cycle strobe; `dout` is valid on that cycle.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE → RESET → SAMPLE → SHARE → CONV → DONE → IDLE.
- IDLE:
  - `start`=1 at an edge → RESET.
  - Phase counter loads RST_CYC-1.
- RESET:
  - `snh_rst`=1.
  - Counter decrements each cycle. At 0 → SAMPLE, counter loads SMP_CYC-1.
- SAMPLE:
  - `sample`=1. At counter 0 → SHARE.
  - `snh_rst` and `sample` are never high in the same cycle.
- SHARE:
  - `cs_trigger`=1 for exactly one cycle.
  - `dac_code` loads 1<<(NBIT-1). Bit index i=NBIT-1. → CONV.
- CONV:
  - `cmp_en`=1. On each edge, `comp` is registered.
  - If `comp`=0, clear bit i of the code.
  - If i>0, set bit i-1 and decrement i. If i=0, → DONE.
- DONE:
  - `dout` ← final code. `dout_valid`=1 for one cycle.
  - `dac_code` holds the final code.
  - → IDLE.
- `start` is ignored outside IDLE. A held `start` restarts on the first IDLE edge.
- All outputs are registered. No combinational path from `comp` or `start` to any output.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counter and bit index 0.
- `rstn` low mid-conversion:
  - Outputs clear immediately.
  - A partially resolved code is discarded. `dout` is cleared to 0.
- Latency from the edge accepting `start` to `dout_valid` high: RST_CYC + SMP_CYC + NBIT + 2 cycles. Defaults give 16.
- `busy` rises one cycle after `start` is accepted. It falls on the edge leaving DONE.
- `comp` must be settled before the edge that ends each CONV cycle. One decision is consumed per cycle.
- `cs_trigger` rises in the cycle right after `sample` falls. This separates the S/H pedestal transient from charge sharing.
- All-ones input (`comp` always 1): `dout` = 2^NBIT-1.
- All-zeros input (`comp` always 0): `dout` = 0.

## Configuration
- Macro: `SAR_CTRL_FREERUN_EN`.
- Defined: DONE goes directly to RESET (free-running), regardless of `start`. The first conversion still needs `start`. `busy` stays high after the first `start`.
- Undefined: DONE → IDLE as described above.

## Structure
- Shared package `sar_pkg` holds:
  - the `sar_state_t` enum (IDLE, RESET, SAMPLE, SHARE, CONV, DONE);
  - `SAR_NBIT_MAX`=16;
  - a localparam function for the conversion latency.
- One sub-module, `sar_phase_cnt`: a loadable down-counter with a zero flag, shared by RESET and SAMPLE timing.
- The bit index lives in `sar_ctrl` itself.

## Test plan
- Reset during SAMPLE (`rstn` low mid-phase) → all outputs 0 immediately; the next `start` yields a normal full sequence.
- NBIT=8, `comp` modelled as (vin_code ≥ `dac_code`) with vin_code=0xA5 → `dout`=0xA5, `dout_valid` high on cycle 16 after `start`.
- `comp` stuck 1 → `dout`=0xFF; `comp` stuck 0 → `dout`=0x00. `dac_code` sequence for stuck 0: 0x80, 0x40, …, 0x01, 0x00.
- Phase check with RST_CYC=3, SMP_CYC=5:
  - `snh_rst` high exactly 3 cycles, then `sample` exactly 5, never overlapping;
  - `cs_trigger` a single cycle directly after `sample` falls.
- `start` pulsed during CONV → ignored; no second `dout_valid` until a new `start` in IDLE.
- With `SAR_CTRL_FREERUN_EN`, a single `start` → back-to-back conversions every 16 cycles with `busy` continuously high.
